// File: rtl/ram_port_arbiter_if.sv
// Requester-side port of the RAM arbiter.
// Client drives the request bundle, arbiter returns grant and read data.
interface ram_port_arbiter_if #(
    parameter int Data_width = 32,
    parameter int Addr_width = 7
);
    logic                  req;
    logic                  lock;
    logic                  we;
    logic [Addr_width-1:0] addr;
    logic [Data_width-1:0] wdata;
    logic                  gnt;
    logic                  rvalid;
    logic [Data_width-1:0] rdata;

    modport master (
        output req, lock, we, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, lock, we, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter for a single-port RAM with registered read address.
// Round-robin grant, optional bounded lock, per-requester read return pipes.
module ram_port_arbiter #(
    parameter int Data_width = 32,
    parameter int Addr_width = 7,
    parameter int LOCK_MAX   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ram_port_arbiter_if.slave     a,
    ram_port_arbiter_if.slave     b,
    output logic                  ram_we,
    output logic [Addr_width-1:0] ram_addr,
    output logic [Data_width-1:0] ram_d,
    input  logic [Data_width-1:0] ram_q
);

    localparam int CW = $clog2(LOCK_MAX + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_MAX - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            rr_q, rr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            gnt_a, gnt_b;
    logic            rd_a_q, rd_b_q;

    assign a.gnt = gnt_a;
    assign b.gnt = gnt_b;

    // Grant selection; forced low while reset is held.
    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        unique case (state_q)
            IDLE: begin
                gnt_a = a.req && !(b.req && rr_q);
                gnt_b = b.req && !gnt_a;
            end
            OWN_A:   gnt_a = a.req;
            OWN_B:   gnt_b = b.req;
            default: ;
        endcase
        if (!rst_n) begin
            gnt_a = 1'b0;
            gnt_b = 1'b0;
        end
    end

    // Next state, round-robin pointer and lock starvation counter.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        if (gnt_a) rr_d = 1'b1;
        if (gnt_b) rr_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (gnt_a && a.lock) begin
                    state_d = OWN_A;
                    cnt_d   = '0;
                end else if (gnt_b && b.lock) begin
                    state_d = OWN_B;
                    cnt_d   = '0;
                end
            end
            OWN_A: begin
                if (b.req && cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    rr_d    = 1'b1;
                    cnt_d   = '0;
                end else if (!a.lock) begin
                    state_d = IDLE;
                end else if (b.req) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            OWN_B: begin
                if (a.req && cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    rr_d    = 1'b0;
                    cnt_d   = '0;
                end else if (!b.lock) begin
                    state_d = IDLE;
                end else if (a.req) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // RAM bus follows the granted requester, idles at zero.
    always_comb begin
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_d    = '0;
        if (gnt_a) begin
            ram_we   = a.we;
            ram_addr = a.addr;
            ram_d    = a.wdata;
        end else if (gnt_b) begin
            ram_we   = b.we;
            ram_addr = b.addr;
            ram_d    = b.wdata;
        end
    end

    // Arbitration state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Read return: mark accepted read, capture ram_q one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_a_q   <= 1'b0;
            rd_b_q   <= 1'b0;
            a.rvalid <= 1'b0;
            b.rvalid <= 1'b0;
            a.rdata  <= '0;
            b.rdata  <= '0;
        end else begin
            rd_a_q   <= gnt_a && !a.we;
            rd_b_q   <= gnt_b && !b.we;
            a.rvalid <= rd_a_q;
            b.rvalid <= rd_b_q;
            if (rd_a_q) a.rdata <= ram_q;
            if (rd_b_q) b.rdata <= ram_q;
        end
    end

endmodule
